jtcontra_snd_romarb: RTL and testbench

JTCONTRA_SND_ROMARB -- requirements
Module: jtcontra_snd_romarb

---
 rtl/jtcontra_snd_romarb.sv | 159 +++++++++++++++
 tb/tb_jtcontra_snd_romarb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_snd_romarb.sv
// Sound ROM arbiter: shares one ROM port between the sound CPU and the ADPCM
// reader, each fronted by a one-byte cache entry (tag, data, valid).
module jtcontra_snd_romarb #(
  parameter logic [17:0] PCM_OFFSET = 18'h08000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_ok,
  input  logic        pcm_cs,
  input  logic [16:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rom_cs_q, rom_cs_d;
  logic [17:0] rom_addr_q, rom_addr_d;
  logic [16:0] req_addr_q, req_addr_d;
  logic        gnt_pcm_q, gnt_pcm_d;
  logic        last_pcm_q, last_pcm_d;
  logic [14:0] cpu_tag_q, cpu_tag_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic        cpu_valid_q, cpu_valid_d;
  logic [16:0] pcm_tag_q, pcm_tag_d;
  logic [7:0]  pcm_data_q, pcm_data_d;
  logic        pcm_valid_q, pcm_valid_d;

  logic        cpu_hit_s, pcm_hit_s;
  logic        cpu_miss_s, pcm_miss_s;
  logic        pick_pcm_s;
  logic [17:0] pcm_rom_addr_s;

  assign cpu_hit_s      = cpu_valid_q && (cpu_tag_q == cpu_addr);
  assign pcm_hit_s      = pcm_valid_q && (pcm_tag_q == pcm_addr);
  assign cpu_ok         = cpu_cs && cpu_hit_s;
  assign pcm_ok         = pcm_cs && pcm_hit_s;
  assign cpu_miss_s     = cpu_cs && !cpu_hit_s;
  assign pcm_miss_s     = pcm_cs && !pcm_hit_s;
  assign pcm_rom_addr_s = PCM_OFFSET + {1'b0, pcm_addr};

  // On a tie the requester that lost the previous tie wins; a lone miss is
  // always granted and does not move the tie-break pointer.
  assign pick_pcm_s = pcm_miss_s && (!cpu_miss_s || !last_pcm_q);

  assign cpu_data = cpu_data_q;
  assign pcm_data = pcm_data_q;
  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;

  // Next-state and cache-fill logic
  always_comb begin
    state_d     = state_q;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    req_addr_d  = req_addr_q;
    gnt_pcm_d   = gnt_pcm_q;
    last_pcm_d  = last_pcm_q;
    cpu_tag_d   = cpu_tag_q;
    cpu_data_d  = cpu_data_q;
    cpu_valid_d = cpu_valid_q;
    pcm_tag_d   = pcm_tag_q;
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q;
    case (state_q)
      IDLE: begin
        if (cpu_miss_s || pcm_miss_s) begin
          gnt_pcm_d = pick_pcm_s;
          if (cpu_miss_s && pcm_miss_s) begin
            last_pcm_d = pick_pcm_s;
          end else begin
            last_pcm_d = last_pcm_q;
          end
          if (pick_pcm_s) begin
            rom_addr_d = pcm_rom_addr_s;
            req_addr_d = pcm_addr;
          end else begin
            rom_addr_d = {3'b000, cpu_addr};
            req_addr_d = {2'b00, cpu_addr};
          end
          rom_cs_d = 1'b1;
          state_d  = ISSUE;
        end else begin
          rom_cs_d = 1'b0;
          state_d  = IDLE;
        end
      end
      // rom_ok here still belongs to the previous access
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (rom_ok) begin
          if (gnt_pcm_q) begin
            pcm_tag_d   = req_addr_q;
            pcm_data_d  = rom_data;
            pcm_valid_d = 1'b1;
          end else begin
            cpu_tag_d   = req_addr_q[14:0];
            cpu_data_d  = rom_data;
            cpu_valid_d = 1'b1;
          end
          rom_cs_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State registers; reset points the tie-break at PCM so the CPU wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= 18'd0;
      req_addr_q  <= 17'd0;
      gnt_pcm_q   <= 1'b0;
      last_pcm_q  <= 1'b1;
      cpu_tag_q   <= 15'd0;
      cpu_data_q  <= 8'd0;
      cpu_valid_q <= 1'b0;
      pcm_tag_q   <= 17'd0;
      pcm_data_q  <= 8'd0;
      pcm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      req_addr_q  <= req_addr_d;
      gnt_pcm_q   <= gnt_pcm_d;
      last_pcm_q  <= last_pcm_d;
      cpu_tag_q   <= cpu_tag_d;
      cpu_data_q  <= cpu_data_d;
      cpu_valid_q <= cpu_valid_d;
      pcm_tag_q   <= pcm_tag_d;
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

endmodule

// File: tb/tb_jtcontra_snd_romarb.sv
// Directed bench for jtcontra_snd_romarb: a vector table of single-requester
// transactions plus hand sequences for ties, dropped requests and reset.
module tb_jtcontra_snd_romarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ok;
  logic        pcm_cs;
  logic [16:0] pcm_addr;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtcontra_snd_romarb dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cs   (cpu_cs),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ok   (cpu_ok),
    .pcm_cs   (pcm_cs),
    .pcm_addr (pcm_addr),
    .pcm_data (pcm_data),
    .pcm_ok   (pcm_ok),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  typedef struct {
    logic        cpu_cs;
    logic [14:0] cpu_addr;
    logic        pcm_cs;
    logic [16:0] pcm_addr;
    logic        miss;
    logic [17:0] exp_rom_addr;
    int          dly;
    logic [7:0]  data;
    logic        exp_cpu_ok;
    logic        exp_pcm_ok;
    logic [7:0]  exp_cpu_data;
    logic [7:0]  exp_pcm_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for rom_cs to rise, then check the presented address.
  task automatic wait_issue(input logic [17:0] exp_addr, input string name, output int waited);
    waited = 0;
    while (!rom_cs && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_rom_cs"}, {31'd0, rom_cs}, 32'd1);
    check({name, "_rom_addr"}, {14'd0, rom_addr}, {14'd0, exp_addr});
  endtask

  // Called at the first negedge with rom_cs high (ISSUE). rom_ok is raised
  // dly cycles later; with dly=0 it is already high (stale) during ISSUE and
  // carries junk data there, so a fill taken in ISSUE would be visible.
  task automatic respond(input logic [7:0] data, input int dly, input string name);
    int k;
    int need;
    need = (dly < 1) ? 2 : dly + 1;
    k = 0;
    while (rom_cs && k < 20) begin
      rom_ok   = (k >= dly);
      rom_data = (k >= ((dly < 1) ? 1 : dly)) ? data : 8'hEE;
      @(negedge clk);
      k++;
    end
    rom_ok = 1'b0;
    check({name, "_fill_cycles"}, k, need);
  endtask

  initial begin
    int waited;

    //            cpu_cs cpu_addr  pcm_cs pcm_addr  miss exp_rom   dly data   cok pok cdata  pdata
    vecs[0] = '{1'b1, 15'h0100, 1'b0, 17'h00000, 1'b1, 18'h00100, 1, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 15'h0100, 1'b0, 17'h00000, 1'b0, 18'h00000, 0, 8'h00, 1'b1, 1'b0, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 15'h0100, 1'b1, 17'h1FFFF, 1'b1, 18'h27FFF, 2, 8'h3C, 1'b0, 1'b1, 8'hA5, 8'h3C};
    vecs[3] = '{1'b1, 15'h7FFF, 1'b0, 17'h1FFFF, 1'b1, 18'h07FFF, 0, 8'h5A, 1'b1, 1'b0, 8'h5A, 8'h3C};
    vecs[4] = '{1'b0, 15'h7FFF, 1'b1, 17'h00000, 1'b1, 18'h08000, 3, 8'h81, 1'b0, 1'b1, 8'h5A, 8'h81};
    vecs[5] = '{1'b1, 15'h7FFF, 1'b0, 17'h00000, 1'b0, 18'h00000, 0, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h81};
    vecs[6] = '{1'b0, 15'h7FFF, 1'b1, 17'h00000, 1'b0, 18'h00000, 0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h81};
    vecs[7] = '{1'b1, 15'h0100, 1'b0, 17'h00000, 1'b1, 18'h00100, 1, 8'h42, 1'b1, 1'b0, 8'h42, 8'h81};
    vecs[8] = '{1'b0, 15'h0100, 1'b1, 17'h0ABCD, 1'b1, 18'h12BCD, 1, 8'h99, 1'b0, 1'b1, 8'h42, 8'h99};
    vecs[9] = '{1'b1, 15'h0100, 1'b1, 17'h0ABCD, 1'b0, 18'h00000, 0, 8'h00, 1'b1, 1'b1, 8'h42, 8'h99};

    // Reset state, with requests pending at address 0 (tag 0 but not valid)
    rst = 1'b1; cpu_cs = 1'b1; cpu_addr = 15'h0000; pcm_cs = 1'b1; pcm_addr = 17'h00000;
    rom_data = 8'h00; rom_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("rst_rom_addr", {14'd0, rom_addr}, 32'd0);
    check("rst_cpu_ok", {31'd0, cpu_ok}, 32'd0);
    check("rst_pcm_ok", {31'd0, pcm_ok}, 32'd0);
    check("rst_cpu_data", {24'd0, cpu_data}, 32'd0);
    check("rst_pcm_data", {24'd0, pcm_data}, 32'd0);
    cpu_cs = 1'b0; pcm_cs = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_rom_cs", {31'd0, rom_cs}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_cs = vecs[i].cpu_cs; cpu_addr = vecs[i].cpu_addr;
      pcm_cs = vecs[i].pcm_cs; pcm_addr = vecs[i].pcm_addr;
      if (vecs[i].miss) begin
        wait_issue(vecs[i].exp_rom_addr, $sformatf("v%0d", i), waited);
        check($sformatf("v%0d_issue_delay", i), waited, 1);
        respond(vecs[i].data, vecs[i].dly, $sformatf("v%0d", i));
      end else begin
        repeat (2) @(negedge clk);
      end
      #1;
      check($sformatf("v%0d_rom_cs_low", i), {31'd0, rom_cs}, 32'd0);
      check($sformatf("v%0d_cpu_ok", i), {31'd0, cpu_ok}, {31'd0, vecs[i].exp_cpu_ok});
      check($sformatf("v%0d_pcm_ok", i), {31'd0, pcm_ok}, {31'd0, vecs[i].exp_pcm_ok});
      check($sformatf("v%0d_cpu_data", i), {24'd0, cpu_data}, {24'd0, vecs[i].exp_cpu_data});
      check($sformatf("v%0d_pcm_data", i), {24'd0, pcm_data}, {24'd0, vecs[i].exp_pcm_data});
    end

    // Double miss: first tie goes to the CPU, PCM follows on the next IDLE
    @(negedge clk);
    cpu_cs = 1'b1; cpu_addr = 15'h0200; pcm_cs = 1'b1; pcm_addr = 17'h00200;
    wait_issue(18'h00200, "tie1_first", waited);
    respond(8'h11, 1, "tie1_first");
    wait_issue(18'h08200, "tie1_second", waited);
    check("tie1_second_delay", waited, 1);
    respond(8'h22, 1, "tie1_second");
    #1;
    check("tie1_cpu_ok", {31'd0, cpu_ok}, 32'd1);
    check("tie1_pcm_ok", {31'd0, pcm_ok}, 32'd1);
    check("tie1_cpu_data", {24'd0, cpu_data}, 32'h11);
    check("tie1_pcm_data", {24'd0, pcm_data}, 32'h22);

    // Second tie goes to PCM
    @(negedge clk);
    cpu_addr = 15'h0300; pcm_addr = 17'h00300;
    wait_issue(18'h08300, "tie2_first", waited);
    respond(8'h33, 1, "tie2_first");
    wait_issue(18'h00300, "tie2_second", waited);
    respond(8'h44, 1, "tie2_second");
    #1;
    check("tie2_cpu_data", {24'd0, cpu_data}, 32'h44);
    check("tie2_pcm_data", {24'd0, pcm_data}, 32'h33);
    check("tie2_cpu_ok", {31'd0, cpu_ok}, 32'd1);
    check("tie2_pcm_ok", {31'd0, pcm_ok}, 32'd1);

    // CPU drops cs during WAIT: fill completes, ok stays low until reasserted
    @(negedge clk);
    pcm_cs = 1'b0; cpu_cs = 1'b1; cpu_addr = 15'h0400;
    wait_issue(18'h00400, "drop", waited);
    @(negedge clk);
    cpu_cs = 1'b0; rom_ok = 1'b1; rom_data = 8'h55;
    @(negedge clk);
    rom_ok = 1'b0;
    check("drop_rom_cs_after_fill", {31'd0, rom_cs}, 32'd0);
    check("drop_cpu_ok_low", {31'd0, cpu_ok}, 32'd0);
    repeat (2) @(negedge clk);
    check("drop_no_reissue", {31'd0, rom_cs}, 32'd0);
    cpu_cs = 1'b1;
    #1;
    check("drop_cpu_ok_reassert", {31'd0, cpu_ok}, 32'd1);
    check("drop_cpu_data", {24'd0, cpu_data}, 32'h55);

    // CPU changes address during WAIT: entry holds the original address
    @(negedge clk);
    cpu_addr = 15'h0600;
    wait_issue(18'h00600, "chg", waited);
    @(negedge clk);
    cpu_addr = 15'h0700; rom_ok = 1'b1; rom_data = 8'h66;
    @(negedge clk);
    rom_ok = 1'b0;
    check("chg_cpu_ok_low", {31'd0, cpu_ok}, 32'd0);
    check("chg_cpu_data", {24'd0, cpu_data}, 32'h66);
    wait_issue(18'h00700, "chg_new", waited);
    check("chg_new_delay", waited, 1);
    respond(8'h77, 1, "chg_new");
    #1;
    check("chg_new_cpu_ok", {31'd0, cpu_ok}, 32'd1);
    check("chg_new_cpu_data", {24'd0, cpu_data}, 32'h77);

    // Reset during WAIT drops rom_cs and both ok outputs; request reissues
    @(negedge clk);
    cpu_addr = 15'h0800; pcm_cs = 1'b1; pcm_addr = 17'h00300;
    #1;
    check("rstw_pcm_ok_before", {31'd0, pcm_ok}, 32'd1);
    wait_issue(18'h00800, "rstw", waited);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_rom_cs", {31'd0, rom_cs}, 32'd0);
    check("rstw_rom_addr", {14'd0, rom_addr}, 32'd0);
    check("rstw_cpu_ok", {31'd0, cpu_ok}, 32'd0);
    check("rstw_pcm_ok", {31'd0, pcm_ok}, 32'd0);
    @(negedge clk);
    pcm_cs = 1'b0;
    rst = 1'b0;
    wait_issue(18'h00800, "rstw_reissue", waited);
    respond(8'h88, 1, "rstw_reissue");
    #1;
    check("rstw_cpu_ok_after", {31'd0, cpu_ok}, 32'd1);
    check("rstw_cpu_data", {24'd0, cpu_data}, 32'h88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
